systolic_skew_feeder: RTL and testbench

//   Operand feeder directly upstream of a row/column edge of the mac_pe systolic array.

---
 rtl/systolic_skew_feeder_pkg.sv | 24 ++
 rtl/systolic_skew_feeder_delay.sv | 44 ++++
 rtl/systolic_skew_feeder.sv | 106 ++++++++++
 tb/tb_systolic_skew_feeder.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_pkg : shared types and helpers for the systolic array     |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
package systolic_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int ACC_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

  // Bit offset of a lane inside a packed multi-lane vector.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_skew_feeder_delay.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | skew_delay_line : DEPTH-stage registered data+valid shift line     |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module skew_delay_line
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o
);

  logic [DATA_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < DEPTH; s++) begin
        data_q[s] <= '0;
      end
      valid_q <= '0;
    end else begin
      // Data is zeroed at entry so an invalid slot never carries a stale operand.
      data_q[0]  <= valid_i ? data_i : '0;
      valid_q[0] <= valid_i;
      for (int s = 1; s < DEPTH; s++) begin
        data_q[s]  <= data_q[s-1];
        valid_q[s] <= valid_q[s-1];
      end
    end
  end

  assign data_o  = data_q[DEPTH-1];
  assign valid_o = valid_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_skew_feeder : skews an operand vector onto a PE array edge|
// | Revision             : 1.0                                         |
// +--------------------------------------------------------------------+
module systolic_skew_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = systolic_pkg::DATA_WIDTH,
  parameter int N_LANES    = 4,
  parameter int K_MAX      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [$clog2(K_MAX+1)-1:0]    k_len,
  input  logic [N_LANES*DATA_WIDTH-1:0] in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [N_LANES*DATA_WIDTH-1:0] lane_data_out,
  output logic [N_LANES-1:0]            lane_valid_out,
  output logic                          busy,
  output logic                          done
);

  localparam int KW = $clog2(K_MAX+1);
  localparam int FW = (N_LANES > 1) ? $clog2(N_LANES) : 1;

  feeder_state_e state_q, state_d;
  logic [KW-1:0] beat_cnt_q, beat_cnt_d;
  logic [KW-1:0] klen_q, klen_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic          accept;
  logic          last_beat;

  assign in_ready  = (state_q == LOAD);
  assign accept    = in_valid & in_ready;
  assign last_beat = accept && ((beat_cnt_q + KW'(1)) == klen_q);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    klen_d      = klen_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          klen_d      = k_len;
          beat_cnt_d  = '0;
          flush_cnt_d = '0;
          state_d     = (k_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + KW'(1);
          if (last_beat) begin
            flush_cnt_d = '0;
            state_d     = (N_LANES == 1) ? DONE : FLUSH;
          end
        end
      end
      FLUSH: begin
        // N_LANES-1 cycles here lines DONE up with the last beat leaving the deepest lane.
        flush_cnt_d = flush_cnt_q + FW'(1);
        if (flush_cnt_q == FW'(N_LANES-2)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= '0;
      klen_q      <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      klen_q      <= klen_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    skew_delay_line #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (i + 1)
    ) u_delay (
      .clk     (clk),
      .rst_n   (rst_n),
      .data_i  (in_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .valid_i (accept),
      .data_o  (lane_data_out[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
      .valid_o (lane_valid_out[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_skew_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_systolic_skew_feeder : scoreboard bench for the skew feeder     |
// | Revision                : 1.0                                      |
// +--------------------------------------------------------------------+
module tb_systolic_skew_feeder;

  localparam int DW = 8;
  localparam int NL = 4;
  localparam int KM = 16;
  localparam int KW = $clog2(KM+1);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic [NL*DW-1:0]  in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NL*DW-1:0]  lane_data_out;
  logic [NL-1:0]     lane_valid_out;
  logic              busy;
  logic              done;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    int          cyc;
    logic [DW-1:0] data;
  } exp_t;

  exp_t lane_q [NL][$];
  int   done_q [$];
  exp_t me;

  systolic_skew_feeder #(
    .DATA_WIDTH (DW),
    .N_LANES    (NL),
    .K_MAX      (KM)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .k_len          (k_len),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .lane_data_out  (lane_data_out),
    .lane_valid_out (lane_valid_out),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every lane beat and every done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NL; i++) begin
        if (lane_valid_out[i]) begin
          if (lane_q[i].size() == 0) begin
            check($sformatf("lane%0d_spurious_valid", i), 64'd1, 64'd0);
          end else begin
            me = lane_q[i].pop_front();
            check($sformatf("lane%0d_cycle", i), 64'(cyc), 64'(me.cyc));
            check($sformatf("lane%0d_data", i), 64'(lane_data_out[i*DW +: DW]), 64'(me.data));
          end
        end else begin
          check($sformatf("lane%0d_invalid_data_zero", i), 64'(lane_data_out[i*DW +: DW]), 64'd0);
          if (lane_q[i].size() > 0 && lane_q[i][0].cyc <= cyc) begin
            me = lane_q[i].pop_front();
            check($sformatf("lane%0d_missing_valid", i), 64'd0, 64'd1);
          end
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          check("done_cycle", 64'(cyc), 64'(done_q.pop_front()));
        end
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        void'(done_q.pop_front());
        check("missing_done", 64'd0, 64'd1);
      end
    end
  end

  // One job from an IDLE negedge to the next IDLE negedge.
  // mode 0: in_valid always high, directed data; 1: random gaps, random data;
  // mode 2: directed data with a single bubble after the first beat.
  task automatic run_job(input int k, input int mode);
    int sent;
    int step;
    logic v;
    logic [NL*DW-1:0] d;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_ready", 64'(in_ready), 64'd0);
    start    = 1'b1;
    k_len    = KW'(k);
    in_valid = 1'b0;
    if (k == 0) begin
      done_q.push_back(cyc + 1);
      @(negedge clk);
      check("k0_busy", 64'(busy), 64'd1);
      check("k0_ready", 64'(in_ready), 64'd0);
      start    = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      in_data  = NL*DW'($urandom);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    sent = 0;
    step = 0;
    while (sent < k) begin
      check("load_ready", 64'(in_ready), 64'd1);
      check("load_busy", 64'(busy), 64'd1);
      start = 1'($urandom_range(0, 1));
      k_len = KW'($urandom_range(0, KM));
      case (mode)
        0:       v = 1'b1;
        2:       v = (step != 1);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      for (int i = 0; i < NL; i++) begin
        d[i*DW +: DW] = (mode == 1 || !v) ? DW'($urandom) : DW'(NL*sent + i + 1);
      end
      in_valid = v;
      in_data  = d;
      if (v) begin
        // Accept lands on the coming edge; lane i shows it i cycles after lane 0.
        for (int i = 0; i < NL; i++) begin
          lane_q[i].push_back('{cyc: cyc + 1 + i, data: d[i*DW +: DW]});
        end
        sent++;
        if (sent == k) done_q.push_back(cyc + NL);
      end
      step++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int j = 0; j < NL; j++) begin
      check("drain_ready", 64'(in_ready), 64'd0);
      check("drain_busy", 64'(busy), 64'd1);
      start    = 1'($urandom_range(0, 1));
      in_valid = 1'($urandom_range(0, 1));
      in_data  = NL*DW'($urandom);
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #1;
    check("rst_valid", 64'(lane_valid_out), 64'd0);
    check("rst_data", 64'(lane_data_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_job(3, 0);
    @(negedge clk);
    run_job(3, 2);
    run_job(0, 0);
    @(negedge clk);

    // Asynchronous reset after two beats of a four-beat job.
    start = 1'b1;
    k_len = KW'(4);
    @(negedge clk);
    start = 1'b0;
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NL; i++) in_data[i*DW +: DW] = DW'($urandom_range(1, 255));
      in_valid = 1'b1;
      for (int i = 0; i < NL; i++) lane_q[i].push_back('{cyc: cyc + 1 + i, data: in_data[i*DW +: DW]});
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(lane_valid_out), 64'd0);
    check("arst_data", 64'(lane_data_out), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < NL; i++) lane_q[i].delete();
    done_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < NL + 2; j++) @(negedge clk);

    run_job(4, 0);
    for (int n = 0; n < 20; n++) begin
      run_job(int'($urandom_range(0, KM)), 1);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    for (int j = 0; j < NL + 2; j++) @(negedge clk);
    for (int i = 0; i < NL; i++) begin
      check($sformatf("lane%0d_leftover", i), 64'(lane_q[i].size()), 64'd0);
    end
    check("done_leftover", 64'(done_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
